noc_link_tx: RTL

Credit-based link transmitter that drives flits from a router output port into the input FIFO of the neighbouring router. It keeps a local mirror of the remote FIFO's free slots as a credit counter. It accepts flits from the local output arbiter only while credits are available, so the remote FIFO never sees a write while full. It also tracks packet framing (head/body/tail) so that upstream logic knows when a packet is in flight on the link.

---
 rtl/noc_link_pkg.sv | 26 ++
 rtl/noc_link_tx_if.sv | 22 ++
 rtl/noc_link_credit_cnt.sv | 55 +++++
 rtl/noc_link_tx.sv | 116 +++++++++++
 4 files changed

// File: rtl/noc_link_pkg.sv
// Shared types and helpers for the credit-based NoC link transmitter.
package noc_link_pkg;

  localparam int FLIT_TYPE_W = 2;
  // Widest flit the type helper can look into.
  localparam int MAX_FLIT_W = 256;

  typedef enum logic [FLIT_TYPE_W-1:0] {
    FT_HEAD      = 2'b00,
    FT_BODY      = 2'b01,
    FT_TAIL      = 2'b10,
    FT_HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OPEN = 1'b1
  } link_state_e;

  // Type field lives in the two most significant bits of a flit of 'width' bits.
  function automatic flit_type_e flit_type(input logic [MAX_FLIT_W-1:0] flit,
                                           input int unsigned width);
    return flit_type_e'({flit[width-1], flit[width-2]});
  endfunction

endpackage

// File: rtl/noc_link_tx_if.sv
// Local-arbiter and link-side handshake bundle of the link transmitter.
// master: the transmitter; slave: the surrounding router / remote side.
interface noc_link_tx_if #(
  parameter int FLIT_WIDTH = 34
);
  logic                  in_valid_i;
  logic [FLIT_WIDTH-1:0] in_flit_i;
  logic                  in_ready_o;
  logic                  link_valid_o;
  logic [FLIT_WIDTH-1:0] link_flit_o;
  logic                  link_credit_i;

  modport master (
    input  in_valid_i, in_flit_i, link_credit_i,
    output in_ready_o, link_valid_o, link_flit_o
  );

  modport slave (
    output in_valid_i, in_flit_i, link_credit_i,
    input  in_ready_o, link_valid_o, link_flit_o
  );
endinterface

// File: rtl/noc_link_credit_cnt.sv
// Saturating up/down counter mirroring the free slots of the remote FIFO.
module noc_link_credit_cnt #(
  parameter  int MAX = 2,
  localparam int CW  = $clog2(MAX) + 1
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          nonzero,
  output logic          overflow
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;

  // Next credit value: simultaneous inc/dec cancel, inc saturates at MAX.
  always_comb begin
    count_nxt_s = count_r;
    case ({inc, dec})
      2'b10: begin
        if (count_r == MAX_C) begin
          count_nxt_s = count_r;
        end else begin
          count_nxt_s = count_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      2'b01: begin
        if (count_r != {CW{1'b0}}) begin
          count_nxt_s = count_r - {{(CW-1){1'b0}}, 1'b1};
        end else begin
          count_nxt_s = count_r;
        end
      end
      default: count_nxt_s = count_r;
    endcase
  end

  // Credit register, full credit after reset.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      count_r <= MAX_C;
    end else begin
      count_r <= count_nxt_s;
    end
  end

  assign count    = count_r;
  assign nonzero  = (count_r != {CW{1'b0}});
  assign overflow = inc & ~dec & (count_r == MAX_C);

endmodule

// File: rtl/noc_link_tx.sv
// Credit-based link transmitter: credit gating, 1-cycle output register,
// head/tail framing tracker and registered protocol error pulse.
// Optional build macro: LINK_TX_CHECK_EN enables error_o reporting.
module noc_link_tx
  import noc_link_pkg::*;
#(
  parameter  int FLIT_WIDTH   = 34,
  parameter  int REMOTE_SLOTS = 2,
  localparam int CW           = $clog2(REMOTE_SLOTS) + 1
) (
  input  logic           clk,
  input  logic           arst,
  noc_link_tx_if.master  lnk,
  output logic [CW-1:0]  credits_o,
  output logic           busy_o,
  output logic           error_o
);

`ifdef LINK_TX_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  logic                  nonzero_s;
  logic                  overflow_s;
  logic                  accept_s;
  logic                  frame_err_s;
  flit_type_e            type_s;
  link_state_e           state_r;
  link_state_e           state_nxt_s;
  logic                  link_valid_r;
  logic [FLIT_WIDTH-1:0] link_flit_r;
  logic                  error_r;

  noc_link_credit_cnt #(
    .MAX (REMOTE_SLOTS)
  ) u_credit_cnt (
    .clk      (clk),
    .arst     (arst),
    .inc      (lnk.link_credit_i),
    .dec      (accept_s),
    .count    (credits_o),
    .nonzero  (nonzero_s),
    .overflow (overflow_s)
  );

  // Ready depends only on the registered credit count, never on valid.
  assign lnk.in_ready_o = nonzero_s;
  assign accept_s       = lnk.in_valid_i & nonzero_s;
  assign type_s         = flit_type(MAX_FLIT_W'(lnk.in_flit_i), FLIT_WIDTH);

  // Framing next state; illegal types leave the state unchanged and flag an error.
  always_comb begin
    state_nxt_s = state_r;
    frame_err_s = 1'b0;
    if (accept_s) begin
      case (state_r)
        ST_IDLE: begin
          case (type_s)
            FT_HEAD:      state_nxt_s = ST_OPEN;
            FT_HEAD_TAIL: state_nxt_s = ST_IDLE;
            default:      frame_err_s = 1'b1;
          endcase
        end
        ST_OPEN: begin
          case (type_s)
            FT_BODY: state_nxt_s = ST_OPEN;
            FT_TAIL: state_nxt_s = ST_IDLE;
            default: frame_err_s = 1'b1;
          endcase
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Framing state register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Link output stage: strobe follows accept, flit holds when idle.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      link_valid_r <= 1'b0;
      link_flit_r  <= {FLIT_WIDTH{1'b0}};
    end else begin
      link_valid_r <= accept_s;
      if (accept_s) begin
        link_flit_r <= lnk.in_flit_i;
      end
    end
  end

  // Protocol error pulse for the cycle after the offending event.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      error_r <= 1'b0;
    end else begin
      error_r <= CHECK_EN & (frame_err_s | overflow_s);
    end
  end

  assign lnk.link_valid_o = link_valid_r;
  assign lnk.link_flit_o  = link_flit_r;
  assign busy_o           = (state_r == ST_OPEN);
  assign error_o          = error_r;

endmodule
